// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and field layout for the SPI command sequencer.
// Instruction layout, MSB first: ss, rnw, size[1:0], addr, wdata.
package spi_pkg;

    localparam int DWIDTH       = 32;
    localparam int AWIDTH       = 8;
    localparam int S_ADDR_WIDTH = 2;
    localparam int IWIDTH       = S_ADDR_WIDTH + 1 + 2 + AWIDTH + DWIDTH;

    localparam int WDATA_LSB = 0;
    localparam int ADDR_LSB  = DWIDTH;
    localparam int SIZE_LSB  = ADDR_LSB + AWIDTH;
    localparam int RNW_BIT   = SIZE_LSB + 2;
    localparam int SS_LSB    = RNW_BIT + 1;

    typedef struct packed {
        logic [S_ADDR_WIDTH-1:0] ss;
        logic                    rnw;
        logic [1:0]              size;
        logic [AWIDTH-1:0]       addr;
        logic [DWIDTH-1:0]       wdata;
    } spi_instr_t;

    typedef struct packed {
        logic [DWIDTH-1:0]       data;
        logic [S_ADDR_WIDTH-1:0] ss;
        logic [AWIDTH-1:0]       addr;
    } spi_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/spi_cmd_sequencer_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; clr empties it and
// overrides push/pop. A push into a full FIFO succeeds only alongside a pop.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
        if (clr) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + CW'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Head is presented as zero while empty so stale entries never leak out.
    always_comb begin
        if (count_q == {CW{1'b0}}) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Buffers host SPI instructions, hands them to the SPI master on driver_read,
// closes each session with one trailing pop and captures tagged read-back data.
module spi_cmd_sequencer #(
    parameter  int DWIDTH   = spi_pkg::DWIDTH,
    parameter  int AWIDTH   = spi_pkg::AWIDTH,
    parameter  int SS_WIDTH = spi_pkg::S_ADDR_WIDTH,
    parameter  int DEPTH    = 8,
    parameter  int RDEPTH   = 4,
    localparam int IWIDTH   = SS_WIDTH + 3 + AWIDTH + DWIDTH,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int RW       = DWIDTH + SS_WIDTH + AWIDTH,
    localparam int RCW      = $clog2(RDEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IWIDTH-1:0]   cmd_data,
    input  logic [1:0]          cfg_mode,
    input  logic                start,
    input  logic                flush,
    output logic                master_en,
    input  logic                driver_read,
    output logic [IWIDTH-1:0]   driver_data,
    output logic [1:0]          driver_cfg,
    input  logic [DWIDTH-1:0]   spi_slv_read_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DWIDTH-1:0]   rsp_data,
    output logic [SS_WIDTH-1:0] rsp_ss,
    output logic [AWIDTH-1:0]   rsp_addr,
    output logic [CW-1:0]       cmd_count,
    output logic                busy,
    output logic                done,
    output logic                rsp_overflow
);
    import spi_pkg::*;

    seq_state_t          state_q, state_d;
    logic [1:0]          cfg_q, cfg_d;
    logic                ovf_q, ovf_d;
    logic                pend_rd_q, pend_rd_d;
    logic [SS_WIDTH-1:0] pend_ss_q, pend_ss_d;
    logic [AWIDTH-1:0]   pend_addr_q, pend_addr_d;

    logic [IWIDTH-1:0]   cmd_head_s;
    logic [CW-1:0]       cmd_count_s;
    logic [RW-1:0]       rsp_head_s;
    logic [RCW-1:0]      rsp_count_s;
    logic                cmd_empty_s, cmd_ready_s, cmd_pop_s;
    logic                rsp_full_s, rsp_push_s;

    assign cmd_empty_s = (cmd_count_s == {CW{1'b0}});
    assign rsp_full_s  = (rsp_count_s == RCW'(RDEPTH));
    assign cmd_ready_s = rst_n && (cmd_count_s != CW'(DEPTH)) && !flush;

    // Session sequencing, pending-instruction tracking and response capture.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        ovf_d       = ovf_q;
        pend_rd_d   = pend_rd_q;
        pend_ss_d   = pend_ss_q;
        pend_addr_d = pend_addr_q;
        cmd_pop_s   = 1'b0;
        rsp_push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cmd_empty_s) begin
                    state_d = RUN;
                    cfg_d   = cfg_mode;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (driver_read) begin
                    rsp_push_s = pend_rd_q;
                    // A full response FIFO only drops if the host is not popping this cycle.
                    if (pend_rd_q && rsp_full_s && !rsp_ready) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    // A flush in the same cycle leaves nothing to hand out, so the strobe closes.
                    if (!cmd_empty_s && !flush) begin
                        cmd_pop_s   = 1'b1;
                        pend_rd_d   = cmd_head_s[IWIDTH-1-SS_WIDTH];
                        pend_ss_d   = cmd_head_s[IWIDTH-1 -: SS_WIDTH];
                        pend_addr_d = cmd_head_s[DWIDTH +: AWIDTH];
                    end else begin
                        state_d   = DONE;
                        pend_rd_d = 1'b0;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_q       <= 2'b00;
            ovf_q       <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_ss_q   <= {SS_WIDTH{1'b0}};
            pend_addr_q <= {AWIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            ovf_q       <= ovf_d;
            pend_rd_q   <= pend_rd_d;
            pend_ss_q   <= pend_ss_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    spi_sync_fifo #(.WIDTH(IWIDTH), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (cmd_valid && cmd_ready_s),
        .wdata (cmd_data),
        .pop   (cmd_pop_s),
        .rdata (cmd_head_s),
        .count (cmd_count_s)
    );

    spi_sync_fifo #(.WIDTH(RW), .DEPTH(RDEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .push  (rsp_push_s),
        .wdata ({spi_slv_read_data, pend_ss_q, pend_addr_q}),
        .pop   (rsp_ready),
        .rdata (rsp_head_s),
        .count (rsp_count_s)
    );

    assign cmd_ready    = cmd_ready_s;
    assign cmd_count    = cmd_count_s;
    assign driver_data  = cmd_head_s;
    assign driver_cfg   = cfg_q;
    assign master_en    = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign rsp_overflow = ovf_q;
    assign rsp_valid    = (rsp_count_s != {RCW{1'b0}});
    assign rsp_data     = rsp_head_s[RW-1 -: DWIDTH];
    assign rsp_ss       = rsp_head_s[AWIDTH +: SS_WIDTH];
    assign rsp_addr     = rsp_head_s[AWIDTH-1:0];

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench: queue-based session model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_cmd_sequencer;

    localparam int IW     = 45;
    localparam int DEPTH  = 8;
    localparam int RDEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n, cmd_valid, start, flush, driver_read, rsp_ready;
    logic [IW-1:0] cmd_data;
    logic [1:0]    cfg_mode;
    logic [31:0]   spi_slv_read_data;
    logic          cmd_ready, master_en, rsp_valid, busy, done, rsp_overflow;
    logic [IW-1:0] driver_data;
    logic [1:0]    driver_cfg, rsp_ss;
    logic [31:0]   rsp_data;
    logic [7:0]    rsp_addr;
    logic [3:0]    cmd_count;

    int total = 0;
    int bad   = 0;

    spi_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cfg_mode(cfg_mode), .start(start), .flush(flush),
        .master_en(master_en), .driver_read(driver_read), .driver_data(driver_data),
        .driver_cfg(driver_cfg), .spi_slv_read_data(spi_slv_read_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ss(rsp_ss), .rsp_addr(rsp_addr), .cmd_count(cmd_count), .busy(busy),
        .done(done), .rsp_overflow(rsp_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 session running, 2 closing cycle.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  ss;
        logic [7:0]  a;
    } rsp_t;

    logic [IW-1:0] mq[$];
    rsp_t          mrq[$];
    int            mph    = 0;
    logic [1:0]    mcfg   = 2'b00;
    bit            movf   = 1'b0;
    bit            prd    = 1'b0;
    logic [1:0]    pss    = 2'b00;
    logic [7:0]    paddr  = 8'h00;
    bit            mvalid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [1:0] ss, input logic rnw,
                                         input logic [1:0] sz, input logic [7:0] a,
                                         input logic [31:0] d);
        return {ss, rnw, sz, a, d};
    endfunction

    task automatic model_step();
        logic [IW-1:0] instr;
        bit            acc;
        rsp_t          r;
        if (!rst_n) begin
            mq.delete();
            mrq.delete();
            mph = 0; mcfg = 2'b00; movf = 1'b0; prd = 1'b0; pss = 2'b00; paddr = 8'h00;
            mvalid = 1'b1;
            return;
        end
        acc = cmd_valid && (mq.size() < DEPTH) && !flush;
        if (rsp_ready && mrq.size() > 0) void'(mrq.pop_front());
        if (mph == 2) begin
            mph = 0;
        end else if (mph == 0) begin
            if (start && mq.size() > 0) begin
                mph = 1; mcfg = cfg_mode; movf = 1'b0;
            end
        end else if (driver_read) begin
            if (prd) begin
                r.d = spi_slv_read_data; r.ss = pss; r.a = paddr;
                if (mrq.size() < RDEPTH) mrq.push_back(r);
                else movf = 1'b1;
            end
            if (mq.size() > 0 && !flush) begin
                instr = mq.pop_front();
                pss   = 2'((instr >> 43) & 45'h3);
                prd   = ((instr >> 42) & 45'h1) != 45'h0;
                paddr = 8'((instr >> 32) & 45'hFF);
            end else begin
                mph = 2;
                prd = 1'b0;
            end
        end
        if (flush) mq.delete();
        else if (acc) mq.push_back(cmd_data);
    endtask

    // One clock: compare DUT against model with the current inputs, advance model.
    task automatic cyc();
        #1;
        if (mvalid) begin
            chk("cmd_count", 64'(cmd_count), 64'(mq.size()));
            chk("cmd_ready", 64'(cmd_ready), 64'(rst_n && mq.size() < DEPTH && !flush));
            chk("driver_data", 64'(driver_data), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
            chk("master_en", 64'(master_en), 64'(mph == 1));
            chk("busy", 64'(busy), 64'(mph != 0));
            chk("done", 64'(done), 64'(mph == 2));
            chk("driver_cfg", 64'(driver_cfg), 64'(mcfg));
            chk("rsp_overflow", 64'(rsp_overflow), 64'(movf));
            chk("rsp_valid", 64'(rsp_valid), 64'(mrq.size() > 0));
            chk("rsp_data", 64'(rsp_data), (mrq.size() > 0) ? 64'(mrq[0].d) : 64'd0);
            chk("rsp_ss", 64'(rsp_ss), (mrq.size() > 0) ? 64'(mrq[0].ss) : 64'd0);
            chk("rsp_addr", 64'(rsp_addr), (mrq.size() > 0) ? 64'(mrq[0].a) : 64'd0);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cfg_mode = 2'b00; start = 1'b0;
        flush = 1'b0; driver_read = 1'b0; spi_slv_read_data = 32'h0; rsp_ready = 1'b0;
    endtask

    task automatic push_cmd(input logic [IW-1:0] c);
        cmd_valid = 1'b1; cmd_data = c; cyc(); cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        @(negedge clk);
        // Reset with cmd_valid asserted
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = mk(2'd1, 1'b0, 2'd0, 8'h01, 32'h1);
        repeat (3) cyc();
        chk("rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("rst_master_en", 64'(master_en), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        set_idle();
        #1;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write session
        for (int i = 0; i < 3; i++) push_cmd(mk(2'd1, 1'b0, 2'd2, 8'(8'h10 + i), 32'hA5A5A5A5 + 32'(i)));
        start = 1'b1; cfg_mode = 2'b01; cyc(); start = 1'b0; cfg_mode = 2'b00;
        chk("ws_master_en", 64'(master_en), 64'd1);
        chk("ws_driver_cfg", 64'(driver_cfg), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) chk("ws_driver_data", 64'(driver_data),
                           64'(mk(2'd1, 1'b0, 2'd2, 8'(8'h10 + i), 32'hA5A5A5A5 + 32'(i))));
            driver_read = 1'b1; cyc(); driver_read = 1'b0;
            if (i < 3) cyc();
        end
        chk("ws_close_master_en", 64'(master_en), 64'd0);
        chk("ws_done", 64'(done), 64'd1);
        cyc();
        chk("ws_done_pulse", 64'(done), 64'd0);
        chk("ws_busy", 64'(busy), 64'd0);
        chk("ws_rsp_valid", 64'(rsp_valid), 64'd0);

        // Read-back
        push_cmd(mk(2'd2, 1'b1, 2'd2, 8'h20, 32'h0));
        start = 1'b1; cyc(); start = 1'b0;
        driver_read = 1'b1; cyc();
        spi_slv_read_data = 32'hDEADBEEF; cyc();
        driver_read = 1'b0; spi_slv_read_data = 32'h0;
        chk("rb_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rb_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        chk("rb_rsp_ss", 64'(rsp_ss), 64'd2);
        chk("rb_rsp_addr", 64'(rsp_addr), 64'h20);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
        chk("rb_rsp_taken", 64'(rsp_valid), 64'd0);

        // Command FIFO full
        for (int i = 0; i < 8; i++) push_cmd(mk(2'd0, 1'b0, 2'd1, 8'(i), 32'(i)));
        chk("full_count", 64'(cmd_count), 64'd8);
        chk("full_ready", 64'(cmd_ready), 64'd0);
        push_cmd(mk(2'd3, 1'b0, 2'd1, 8'hFF, 32'hFFFF));
        chk("full_ninth", 64'(cmd_count), 64'd8);
        start = 1'b1; cyc(); start = 1'b0;
        driver_read = 1'b1; cyc(); driver_read = 1'b0;
        chk("full_pop_count", 64'(cmd_count), 64'd7);
        chk("full_pop_ready", 64'(cmd_ready), 64'd1);
        flush = 1'b1; cyc(); flush = 1'b0;
        driver_read = 1'b1; cyc(); driver_read = 1'b0; cyc();

        // Response overflow
        for (int i = 0; i < 5; i++) push_cmd(mk(2'd3, 1'b1, 2'd0, 8'(8'h30 + i), 32'h0));
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            driver_read = 1'b1; spi_slv_read_data = 32'h100 + 32'(i); cyc();
        end
        driver_read = 1'b0;
        chk("ovf_flag", 64'(rsp_overflow), 64'd1);
        chk("ovf_head", 64'(rsp_data), 64'h101);
        cyc();
        push_cmd(mk(2'd0, 1'b0, 2'd0, 8'h40, 32'h5));
        start = 1'b1; cyc(); start = 1'b0;
        chk("ovf_cleared", 64'(rsp_overflow), 64'd0);
        driver_read = 1'b1; cyc(); cyc(); driver_read = 1'b0; cyc();
        rsp_ready = 1'b1; repeat (5) cyc(); rsp_ready = 1'b0;

        // Flush mid-session
        for (int i = 0; i < 5; i++) push_cmd(mk(2'd1, 1'b0, 2'd0, 8'(8'h50 + i), 32'(i)));
        start = 1'b1; cyc(); start = 1'b0;
        driver_read = 1'b1; cyc(); cyc(); driver_read = 1'b0;
        chk("fl_count_before", 64'(cmd_count), 64'd3);
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("fl_count", 64'(cmd_count), 64'd0);
        driver_read = 1'b1; cyc(); driver_read = 1'b0;
        chk("fl_done", 64'(done), 64'd1);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n             = ($urandom_range(0, 399) != 0);
            cmd_valid         = ($urandom_range(0, 1) != 0);
            cmd_data          = IW'({$urandom(), $urandom()});
            cfg_mode          = 2'($urandom_range(0, 3));
            start             = ($urandom_range(0, 6) == 0);
            flush             = ($urandom_range(0, 39) == 0);
            driver_read       = ($urandom_range(0, 2) == 0);
            spi_slv_read_data = $urandom();
            rsp_ready         = ($urandom_range(0, 4) < 2);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Synthesizable, parametrised command sequencer that feeds the SPI master. It buffers packed SPI instructions from a host in a command FIFO and presents them on the master's `driver_read`/`driver_data` pop interface under `master_en`. It closes the session with one trailing pop and captures read-back data into a tagged response FIFO. It sits between the host/CPU bus adapter and the SPI master, and replaces the file-based stimulus path in system builds.

## Interface

Parameters:
- `DWIDTH`, 32: data field width.
- `AWIDTH`, 8: address field width.
- `SS_WIDTH`, 2: slave-select field width; up to 2^SS_WIDTH slaves.
- `DEPTH`, 8: command FIFO depth; power of 2, at least 2.
- `RDEPTH`, 4: response FIFO depth; power of 2, at least 2.
- `IWIDTH` (derived): SS_WIDTH+1+2+AWIDTH+DWIDTH. Instruction layout, MSB first: `ss`, `rnw` (1 = read), `size[1:0]`, `addr`, `wdata`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  host offers `cmd_data`.
- `cmd_ready`  out  1  command FIFO can accept.
- `cmd_data`  in  IWIDTH  packed instruction.
- `cfg_mode`  in  2  SPI mode; latched at start.
- `start`  in  1  begin a session; level-sampled in IDLE.
- `flush`  in  1  discard all queued commands.
- `master_en`  out  1  session active to the SPI master.
- `driver_read`  in  1  one-cycle pop strobe from the master.
- `driver_data`  out  IWIDTH  FIFO head; 0 when empty.
- `driver_cfg`  out  2  latched `cfg_mode`.
- `spi_slv_read_data`  in  DWIDTH  read data of the previous instruction, valid with `driver_read`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host takes the response.
- `rsp_data`  out  DWIDTH  read data.
- `rsp_ss`  out  SS_WIDTH  slave tag of the response.
- `rsp_addr`  out  AWIDTH  address tag of the response.
- `cmd_count`  out  $clog2(DEPTH+1)  command FIFO occupancy.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at session close.
- `rsp_overflow`  out  1  sticky flag: a response was dropped.

## Operation

- **Reset:** all registers clear, both FIFOs empty, state is IDLE. `master_en`, `driver_cfg`, `done`, `busy`, `rsp_valid`, `rsp_overflow` and `cmd_count` are all 0.
- **Command FIFO push:** on `cmd_valid && cmd_ready`.
  - `cmd_ready = (cmd_count < DEPTH) && !flush`.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pushes are accepted in every state.
- **Pending register** (`pend_rd`, `pend_ss`, `pend_addr`): records the last instruction handed to the master.
- **IDLE:**
  - `start && cmd_count != 0` → RUN. Also latches `driver_cfg <= cfg_mode` and clears `rsp_overflow`.
  - `start` with an empty FIFO is ignored.
- **RUN** (`master_en` = 1), on `driver_read`:
  - If `pend_rd` = 1, push {`spi_slv_read_data`, `pend_ss`, `pend_addr`} into the response FIFO.
  - If the FIFO is non-empty, pop the head and load the pending register from it.
  - If the FIFO is empty, this is the closing pop: go to DONE and clear `pend_rd`.
- **DONE:** `done` = 1 and `master_en` = 0 for one cycle, then IDLE.
- **Response FIFO full on capture:** the data is dropped and `rsp_overflow` is set. A simultaneous `rsp_ready` pop frees a slot first, so no drop occurs in that case.
- **flush:** empties the command FIFO the next edge, in any state. It takes priority over push and pop. In RUN the next `driver_read` is therefore the closing pop. The response FIFO is not affected.
- **Reset mid-session:** returns to IDLE immediately. No `done` pulse is generated and all data is lost.

## Timing

- `driver_data` is combinational from the FIFO head. A command pushed at edge N is visible after N.
- `start` sampled at edge N → `master_en` = 1 from N to the closing edge.
- Closing `driver_read` at edge M → `master_en` = 0 and `done` = 1 in cycle M..M+1; `busy` drops at M+1.
- Response captured at edge K → `rsp_valid` = 1 after K.
- The response FIFO is show-ahead: the head is visible while `rsp_valid` is high, and it pops on `rsp_valid && rsp_ready`.
- `driver_read` while not in RUN is ignored.

## Structure

- **Package `spi_pkg`:**
  - `DWIDTH`, `AWIDTH`, `S_ADDR_WIDTH`.
  - `IWIDTH` and the field offsets.
  - `typedef struct packed spi_instr_t` (`ss`, `rnw`, `size`, `addr`, `wdata`).
  - `typedef struct packed spi_rsp_t`.
  - `typedef enum logic [1:0] seq_state_t` {IDLE, RUN, DONE}.
- **Sub-module `spi_sync_fifo`** (`WIDTH`, `DEPTH`): show-ahead, with count output. It is instantiated twice, once for commands and once for responses.

## Test plan

1. **Reset:** hold `rst_n` = 0 for 3 cycles with `cmd_valid` = 1.
   - Nothing is pushed and all outputs are 0.
   - After release, `cmd_ready` = 1.
2. **Write session:** push 3 writes (ss=1, addr=0x10, wdata=0xA5A5A5A5, …), then `start` with `cfg_mode` = 01.
   - `master_en` = 1 and `driver_cfg` = 01.
   - Each `driver_read` advances `driver_data`.
   - The 4th `driver_read` produces `master_en` = 0, a 1-cycle `done`, and an empty response FIFO.
3. **Read-back:** issue a read (ss=2, addr=0x20), then a close with `spi_slv_read_data` = 0xDEADBEEF.
   - `rsp_valid` = 1 with `rsp_data` = 0xDEADBEEF, `rsp_ss` = 2, `rsp_addr` = 0x20.
4. **Command FIFO full:** push 8 commands, then a 9th.
   - After 8, `cmd_count` = 8 and `cmd_ready` = 0.
   - The 9th is not accepted.
   - A pop restores `cmd_ready` = 1.
5. **Response overflow:** issue 5 reads with `rsp_ready` = 0.
   - 4 responses are held and `rsp_overflow` = 1.
   - The next `start` clears `rsp_overflow`.
6. **Flush mid-session:** queue 5 commands, pop 2, then pulse `flush`.
   - `cmd_count` = 0.
   - The next `driver_read` closes the session with `done`.
